run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Host-side counterpart of the processor core's start/done handshake.
- Drives the core's start input, waits for done, and measures run length in cycles.
- Enforces a cycle-count timeout.
- After a completed run, streams a window of data memory out over a valid/ready port, for result checking or export.
- Sits beside the core in the top-level harness. Reads data memory through a combinational read port with address in and byte out.

Parameters:
- START_CYCLES, 2: cycles dut_start is held high per run (range 1..15).
- CYC_W, 16: width of cycle_count.
- MAX_CYCLES, 16'hFFFF: RUN cycles allowed before timeout (range 1..2^CYC_W-1).
- DUMP_BASE, 8'd0: first data-memory address streamed.
- DUMP_LEN, 9'd8: bytes streamed per run (range 0..256).

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- go, in, 1: request a run; sampled only in IDLE.
- dut_start, out, 1: to core start input.
- dut_done, in, 1: from core done output.
- mem_raddr, out, 8: data-memory read address.
- mem_rdata, in, 8: data-memory read data, combinational from mem_raddr.
- dump_valid, out, 1: dump beat available.
- dump_ready, in, 1: consumer accepts beat.
- dump_data, out, 8: dump byte.
- dump_addr, out, 8: address of dump_data.
- busy, out, 1: run in progress.
- finished, out, 1: last run complete; sticky until next go.
- timed_out, out, 1: last run hit MAX_CYCLES; sticky until next go.
- cycle_count, out, CYC_W: RUN cycles of last or current run.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state=IDLE.
  - dut_start=0, dump_valid=0, dump_data=0, dump_addr=0.
  - mem_raddr=DUMP_BASE.
  - busy=0, finished=0, timed_out=0, cycle_count=0.
- All outputs are registered.
- IDLE, when go=1:
  - busy<=1, finished<=0, timed_out<=0, cycle_count<=0.
  - dut_start<=1, start counter loaded.
  - Next state START.
  - go is ignored in every other state.
- START:
  - dut_start is high for exactly START_CYCLES consecutive cycles, counted from the first high cycle.
  - dut_start<=0 on the last cycle; next state RUN.
  - dut_done is ignored in START, so a stale done from the previous run is not sampled.
- RUN:
  - dut_done=1: next state DUMP, mem_raddr<=DUMP_BASE, beat counter<=0, cycle_count unchanged.
  - dut_done=1 with DUMP_LEN=0: next state FINISH instead.
  - Otherwise cycle_count<=cycle_count+1.
  - If cycle_count+1 == MAX_CYCLES: timed_out<=1, next state FINISH, no dump.
  - If done and timeout occur in the same cycle, done wins and timed_out stays 0.
- DUMP uses a one-deep registered slice.
  - Load condition: (!dump_valid || dump_ready) && beats_issued<DUMP_LEN.
  - On load: dump_data<=mem_rdata, dump_addr<=mem_raddr, dump_valid<=1, mem_raddr<=mem_raddr+1 (wraps 8'hFF->8'h00), beats_issued++.
  - If dump_valid && dump_ready and no load: dump_valid<=0.
  - While dump_valid && !dump_ready: dump_data and dump_addr stay stable and mem_raddr holds.
  - After the last beat is accepted (beats_accepted==DUMP_LEN): dump_valid<=0, next state FINISH.
  - Throughput is 1 beat/cycle with dump_ready held high; the first beat is valid 1 cycle after entering DUMP.
- FINISH (one cycle):
  - busy<=0, finished<=1, next state IDLE.
  - mem_raddr returns to DUMP_BASE.
- go arriving in the same cycle FINISH completes is ignored; it takes effect from IDLE on the following cycle.

Decomposition:
- Package run_seq_pkg holds:
  - typedef enum logic [2:0] {IDLE, START, RUN, DUMP, FINISH} run_state_t.
  - Default parameter constants.
- One sub-module, dump_streamer, contains the address counter, the beat issued/accepted counters and the valid/ready output register.
  - Inputs: clk, reset, load_base, mem_rdata, dump_ready.
  - Outputs: mem_raddr, dump_valid, dump_data, dump_addr, all_accepted.

Test Plan:
- Basic run: reset, pulse go for 1 cycle; bench core raises dut_done 10 cycles after dut_start falls. Required response:
  - dut_start high exactly 2 cycles.
  - cycle_count=10.
  - 8 beats at dump_addr 0..7 carrying memory contents.
  - busy falls and finished=1.
- Backpressure: memory [0..7]=8'h10..8'h17, dump_ready toggling 1/0 each cycle. Required response:
  - Beats 8'h10..8'h17 in order, none duplicated or skipped.
  - dump_data stable whenever valid && !ready.
- Timeout: MAX_CYCLES=20, dut_done never asserted. Required response:
  - After 20 RUN cycles: timed_out=1, finished=1, cycle_count=20.
  - dump_valid never asserted.
- Done/timeout tie: MAX_CYCLES=5, dut_done raised in the 5th RUN cycle. Required response:
  - timed_out=0.
  - Dump occurs.
  - cycle_count=4.
- Wrap and stale done:
  - DUMP_BASE=8'hFE, DUMP_LEN=4: dump_addr sequence FE, FF, 00, 01.
  - dut_done held high through START: the sequencer still enters RUN first, then DUMP with cycle_count=0.
- Reset mid-DUMP: assert reset during the 3rd beat. Required response:
  - All outputs immediately at reset values.
  - A subsequent go runs cleanly from beat 0.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer and its dump streamer.
package run_seq_pkg;

  typedef enum logic [2:0] {IDLE, START, RUN, DUMP, FINISH} run_state_t;

  localparam int unsigned DEF_START_CYCLES = 2;
  localparam int unsigned DEF_CYC_W        = 16;
  localparam int unsigned DEF_MAX_CYCLES   = 32'h0000_FFFF;
  localparam logic [7:0]  DEF_DUMP_BASE    = 8'd0;
  localparam int unsigned DEF_DUMP_LEN     = 8;

  // Beat counters must represent 0..256.
  localparam int unsigned BEAT_W = 9;

endpackage

// File: rtl/dump_streamer.sv
// Streams DUMP_LEN bytes of data memory out through a one-deep valid/ready register slice.
// Idles with both beat counters at DUMP_LEN; load_base rearms it for a new window.
module dump_streamer
  import run_seq_pkg::*;
#(
  parameter logic [7:0]  DUMP_BASE = DEF_DUMP_BASE,
  parameter int unsigned DUMP_LEN  = DEF_DUMP_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_base,
  input  logic [7:0] mem_rdata,
  input  logic       dump_ready,
  output logic [7:0] mem_raddr,
  output logic       dump_valid,
  output logic [7:0] dump_data,
  output logic [7:0] dump_addr,
  output logic       all_accepted
);

  localparam logic [BEAT_W-1:0] LEN = BEAT_W'(DUMP_LEN);

  logic [7:0]        raddr_q, raddr_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        addr_q, addr_d;
  logic [BEAT_W-1:0] issued_q, issued_d;
  logic [BEAT_W-1:0] accepted_q, accepted_d;
  logic              load, accept;

  assign all_accepted = (accepted_q == LEN);
  assign mem_raddr    = raddr_q;
  assign dump_valid   = valid_q;
  assign dump_data    = data_q;
  assign dump_addr    = addr_q;

  // Slice load/drain and address/beat bookkeeping.
  always_comb begin
    raddr_d    = raddr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    load       = (!valid_q || dump_ready) && (issued_q < LEN);
    accept     = valid_q && dump_ready;
    if (load_base) begin
      raddr_d    = DUMP_BASE;
      valid_d    = 1'b0;
      issued_d   = '0;
      accepted_d = '0;
    end else begin
      if (load) begin
        data_d   = mem_rdata;
        addr_d   = raddr_q;
        valid_d  = 1'b1;
        raddr_d  = raddr_q + 8'd1;
        issued_d = issued_q + 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end
      if (accept) accepted_d = accepted_q + 1'b1;
      // Window drained: park the read address back at the base.
      if (all_accepted) raddr_d = DUMP_BASE;
    end
  end

  // Slice and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_q    <= DUMP_BASE;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      addr_q     <= 8'd0;
      issued_q   <= LEN;
      accepted_q <= LEN;
    end else begin
      raddr_q    <= raddr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side run sequencer: pulses the core's start, times the run against a cycle budget,
// then streams a data-memory window out over valid/ready.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned START_CYCLES = DEF_START_CYCLES,
  parameter int unsigned CYC_W        = DEF_CYC_W,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter logic [7:0]  DUMP_BASE    = DEF_DUMP_BASE,
  parameter int unsigned DUMP_LEN     = DEF_DUMP_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             dut_start,
  input  logic             dut_done,
  output logic [7:0]       mem_raddr,
  input  logic [7:0]       mem_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [7:0]       dump_data,
  output logic [7:0]       dump_addr,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [CYC_W-1:0] MAX_C   = CYC_W'(MAX_CYCLES);
  localparam logic [3:0]       START_N = 4'(START_CYCLES);

  run_state_t       state_q, state_d;
  logic [3:0]       start_cnt_q, start_cnt_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic             busy_q, busy_d;
  logic             finished_q, finished_d;
  logic             timed_out_q, timed_out_d;
  logic             dut_start_q, dut_start_d;
  logic             load_base;
  logic             all_accepted;
  logic [CYC_W-1:0] cycle_inc;
  logic             hit_max;

  assign cycle_inc   = cycle_count_q + 1'b1;
  assign hit_max     = (cycle_inc == MAX_C);
  assign dut_start   = dut_start_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done beats timeout when both land in the same RUN cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (go) state_d = START;
      START:  if (start_cnt_q == 4'd1) state_d = RUN;
      RUN: begin
        if (dut_done)     state_d = (DUMP_LEN == 0) ? FINISH : DUMP;
        else if (hit_max) state_d = FINISH;
      end
      DUMP:   if (all_accepted) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values for the registered status outputs.
  always_comb begin
    start_cnt_d   = start_cnt_q;
    cycle_count_d = cycle_count_q;
    busy_d        = busy_q;
    finished_d    = finished_q;
    timed_out_d   = timed_out_q;
    dut_start_d   = dut_start_q;
    load_base     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          busy_d        = 1'b1;
          finished_d    = 1'b0;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
          dut_start_d   = 1'b1;
          start_cnt_d   = START_N;
        end
      end
      START: begin
        start_cnt_d = start_cnt_q - 4'd1;
        if (start_cnt_q == 4'd1) dut_start_d = 1'b0;
      end
      RUN: begin
        if (dut_done) begin
          load_base = 1'b1;
        end else begin
          cycle_count_d = cycle_inc;
          if (hit_max) timed_out_d = 1'b1;
        end
      end
      DUMP: ;
      FINISH: begin
        busy_d     = 1'b0;
        finished_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_cnt_q   <= 4'd0;
      cycle_count_q <= '0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      dut_start_q   <= 1'b0;
    end else begin
      start_cnt_q   <= start_cnt_d;
      cycle_count_q <= cycle_count_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timed_out_q   <= timed_out_d;
      dut_start_q   <= dut_start_d;
    end
  end

  dump_streamer #(
    .DUMP_BASE(DUMP_BASE),
    .DUMP_LEN (DUMP_LEN)
  ) u_streamer (
    .clk         (clk),
    .reset       (reset),
    .load_base   (load_base),
    .mem_rdata   (mem_rdata),
    .dump_ready  (dump_ready),
    .mem_raddr   (mem_raddr),
    .dump_valid  (dump_valid),
    .dump_data   (dump_data),
    .dump_addr   (dump_addr),
    .all_accepted(all_accepted)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: several parameterisations share one memory model.
module tb_run_sequencer;

  localparam int NI = 5;
  // 0: defaults, 1: MAX 20, 2: MAX 5, 3: base FE len 4, 4: len 0 with 1 start cycle
  localparam int unsigned PMAX   [NI] = '{65535, 20, 5, 65535, 65535};
  localparam int unsigned PSTART [NI] = '{2, 2, 2, 2, 1};
  localparam int unsigned PLEN   [NI] = '{8, 8, 8, 4, 0};
  localparam logic [7:0]  PBASE  [NI] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h00};

  logic clk = 1'b0;
  logic reset;
  logic go_s   [NI];
  logic done_s [NI];
  logic rdy_s  [NI];
  wire        start_s [NI];
  wire        valid_s [NI];
  wire        busy_s  [NI];
  wire        fin_s   [NI];
  wire        tmo_s   [NI];
  wire [7:0]  raddr_s [NI];
  wire [7:0]  rdata_s [NI];
  wire [7:0]  ddata_s [NI];
  wire [7:0]  daddr_s [NI];
  wire [15:0] cnt_s   [NI];
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign rdata_s[gi] = mem[raddr_s[gi]];
    run_sequencer #(
      .START_CYCLES(PSTART[gi]),
      .CYC_W       (16),
      .MAX_CYCLES  (PMAX[gi]),
      .DUMP_BASE   (PBASE[gi]),
      .DUMP_LEN    (PLEN[gi])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .go         (go_s[gi]),
      .dut_start  (start_s[gi]),
      .dut_done   (done_s[gi]),
      .mem_raddr  (raddr_s[gi]),
      .mem_rdata  (rdata_s[gi]),
      .dump_valid (valid_s[gi]),
      .dump_ready (rdy_s[gi]),
      .dump_data  (ddata_s[gi]),
      .dump_addr  (daddr_s[gi]),
      .busy       (busy_s[gi]),
      .finished   (fin_s[gi]),
      .timed_out  (tmo_s[gi]),
      .cycle_count(cnt_s[gi])
    );
  end

  typedef struct {
    string      name;
    int         k;
    int         delay;    // RUN cycles before done; -1 = never
    bit         stale;    // done held high from before go
    int         rmode;    // 0 ready high, 1 toggle, 2 random
    int         exp_cnt;
    bit         exp_to;
    int         exp_beats;
    logic [7:0] exp_a0;
  } vec_t;

  vec_t vecs [9];

  int n_pass = 0;
  int n_total = 0;

  // Results captured by run_one.
  int         got_start_hi, got_cnt, got_to, got_fin, got_busy_after;
  int         stable_err, saw_valid, hung;
  logic [7:0] beats_a [$];
  logic [7:0] beats_d [$];

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s/%s: got %0d (0x%0h) expected %0d (0x%0h)", tag, what, act, act, exp, exp);
  endtask

  // Runs one go..finished transaction on instance k, acting as core and dump consumer.
  task automatic run_one(input int k, input int delay, input bit stale, input int rmode);
    int run_cyc = 0;
    bit pend = 0;
    logic [7:0] pa = 8'd0, pd = 8'd0;
    beats_a.delete();
    beats_d.delete();
    got_start_hi = 0; stable_err = 0; saw_valid = 0; hung = 1;
    done_s[k] = stale;
    go_s[k] = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      go_s[k] = 1'b0;
      if (fin_s[k] && !busy_s[k]) begin
        hung = 0;
        break;
      end
      if (start_s[k]) got_start_hi++;
      else if (got_start_hi > 0) begin
        run_cyc++;
        if (run_cyc == 1) go_s[k] = 1'b1;  // must be ignored while busy
        if (delay >= 0 && run_cyc > delay) done_s[k] = 1'b1;
      end
      if (pend && !(valid_s[k] && daddr_s[k] == pa && ddata_s[k] == pd)) stable_err++;
      if (valid_s[k]) saw_valid = 1;
      case (rmode)
        0:       rdy_s[k] = 1'b1;
        1:       rdy_s[k] = cyc[0];
        default: rdy_s[k] = 1'($urandom_range(0, 1));
      endcase
      if (valid_s[k] && rdy_s[k]) begin
        beats_a.push_back(daddr_s[k]);
        beats_d.push_back(ddata_s[k]);
      end
      pend = valid_s[k] && !rdy_s[k];
      pa = daddr_s[k];
      pd = ddata_s[k];
    end
    go_s[k] = 1'b0;
    got_cnt = int'(cnt_s[k]);
    got_to  = int'(tmo_s[k]);
    got_fin = int'(fin_s[k]);
    repeat (3) @(negedge clk);
    got_busy_after = int'(busy_s[k]);
  endtask

  task automatic do_checks(input string tag, input int k, input int exp_cnt, input bit exp_to,
                           input int exp_beats, input logic [7:0] exp_a0);
    logic [7:0] ea;
    chk(tag, "hang", hung, 0);
    chk(tag, "start_cycles", got_start_hi, int'(PSTART[k]));
    chk(tag, "cycle_count", got_cnt, exp_cnt);
    chk(tag, "timed_out", got_to, int'(exp_to));
    chk(tag, "finished", got_fin, 1);
    chk(tag, "busy_after", got_busy_after, 0);
    chk(tag, "beat_count", beats_a.size(), exp_beats);
    chk(tag, "saw_valid", saw_valid, (exp_beats > 0) ? 1 : 0);
    chk(tag, "stable", stable_err, 0);
    for (int i = 0; i < beats_a.size() && i < exp_beats; i++) begin
      ea = exp_a0 + 8'(i);
      chk(tag, $sformatf("beat%0d_addr", i), int'(beats_a[i]), int'(ea));
      chk(tag, $sformatf("beat%0d_data", i), int'(beats_d[i]), int'(mem[ea]));
    end
  endtask

  initial begin
    int run_cyc;
    bit seen;
    int ed, ecnt, ebeats;
    bit eto;
    int k;

    vecs[0] = '{"basic",      0, 10, 1'b0, 0, 10, 1'b0, 8, 8'h00};
    vecs[1] = '{"backpress",  0,  3, 1'b0, 1,  3, 1'b0, 8, 8'h00};
    vecs[2] = '{"timeout",    1, -1, 1'b0, 0, 20, 1'b1, 0, 8'h00};
    vecs[3] = '{"tie",        2,  4, 1'b0, 0,  4, 1'b0, 8, 8'h00};
    vecs[4] = '{"just_to",    2,  5, 1'b0, 0,  5, 1'b1, 0, 8'h00};
    vecs[5] = '{"wrap",       3,  2, 1'b0, 0,  2, 1'b0, 4, 8'hFE};
    vecs[6] = '{"stale",      3,  0, 1'b1, 1,  0, 1'b0, 4, 8'hFE};
    vecs[7] = '{"len0",       4,  6, 1'b0, 0,  6, 1'b0, 0, 8'h00};
    vecs[8] = '{"stale_rnd",  0,  0, 1'b1, 2,  0, 1'b0, 8, 8'h00};

    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
    for (int i = 0; i < NI; i++) begin
      go_s[i] = 1'b0; done_s[i] = 1'b0; rdy_s[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset", "busy", int'(busy_s[0]), 0);
    chk("reset", "finished", int'(fin_s[0]), 0);
    chk("reset", "cycle_count", int'(cnt_s[0]), 0);
    chk("reset", "mem_raddr", int'(raddr_s[3]), 8'hFE);
    chk("reset", "dump_valid", int'(valid_s[0]), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_one(vecs[i].k, vecs[i].delay, vecs[i].stale, vecs[i].rmode);
      do_checks(vecs[i].name, vecs[i].k, vecs[i].exp_cnt, vecs[i].exp_to, vecs[i].exp_beats,
                vecs[i].exp_a0);
    end

    // Reset asserted while the third beat is on the port.
    done_s[0] = 1'b0; rdy_s[0] = 1'b1; go_s[0] = 1'b1;
    run_cyc = 0; seen = 0;
    hung = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      go_s[0] = 1'b0;
      if (start_s[0]) seen = 1;
      else if (seen) begin
        run_cyc++;
        if (run_cyc > 2) done_s[0] = 1'b1;
      end
      if (valid_s[0] && daddr_s[0] == 8'd2) begin
        hung = 0;
        break;
      end
    end
    chk("midreset", "reach_beat2", hung, 0);
    reset = 1'b1;
    #1;
    chk("midreset", "dump_valid", int'(valid_s[0]), 0);
    chk("midreset", "dump_addr", int'(daddr_s[0]), 0);
    chk("midreset", "dump_data", int'(ddata_s[0]), 0);
    chk("midreset", "mem_raddr", int'(raddr_s[0]), 0);
    chk("midreset", "busy", int'(busy_s[0]), 0);
    chk("midreset", "cycle_count", int'(cnt_s[0]), 0);
    chk("midreset", "dut_start", int'(start_s[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    done_s[0] = 1'b0;
    @(negedge clk);
    run_one(0, 5, 1'b0, 0);
    do_checks("after_reset", 0, 5, 1'b0, 8, 8'h00);

    // Randomized runs against an outcome model derived from delay vs budget.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      k = int'($urandom_range(0, 1));
      ed = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
      if (k == 0 && ed < 0) ed = 12;
      if (ed >= 0 && ed < int'(PMAX[k])) begin
        ecnt = ed; eto = 1'b0; ebeats = int'(PLEN[k]);
      end else begin
        ecnt = int'(PMAX[k]); eto = 1'b1; ebeats = 0;
      end
      run_one(k, ed, 1'b0, 2);
      do_checks($sformatf("rand%0d", r), k, ecnt, eto, ebeats, PBASE[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
